prefetch_unit: RTL and testbench

Parametrised instruction-fetch front end with a DEPTH-entry prefetch queue. It sits between the synchronous instruction memory and the IF/ID boundary, and replaces the single next_pc register and flush/stall pair. It keeps the memory busy while decode is stalled, and discards wrong-path words on a branch, jump or return redirect. Each delivered instruction is tagged with its PC for branch-target arithmetic in ID.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/prefetch_fifo.sv | 99 +++++++++
 rtl/prefetch_unit.sv | 146 ++++++++++++++
 tb/tb_prefetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the instruction-fetch front end.
//   CPU_ADDR_W / CPU_INST_W : default PC and instruction widths
//   PC_STEP                 : byte distance between sequential instructions
//   fetch_entry_t           : queue entry layout {pc, inst} at the default widths;
//                             the queue stores the same {pc, inst} packing at any width.
package cpu_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_INST_W = 32;
    localparam int PC_STEP    = 4;

    typedef struct packed {
        logic [CPU_ADDR_W-1:0] pc;
        logic [CPU_INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry register queue used as the prefetch buffer.
//   clk, rst      : clock, synchronous active-high reset
//   flush         : drop every entry (pointers and count clear); wins over push/pop
//   push, wdata   : write one entry at the tail
//   pop           : retire the head entry
//   rdata         : head entry (stale contents when empty)
//   count         : occupied entries (registered)
//   full, empty   : occupancy flags
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module prefetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // Pointer and occupancy next-state; flush discards everything at once.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage next-state: only the tail slot can change.
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) begin
            mem_d[wr_ptr_q] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data registers; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head and status outputs, all taken straight from registers.
    always_comb begin
        rdata = mem_q[rd_ptr_q];
        count = count_q;
        full  = (count_q == CNT_W'(DEPTH));
        empty = (count_q == CNT_W'(0));
    end

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction-fetch front end with a DEPTH-entry prefetch queue.
// Keeps the synchronous instruction memory busy while decode stalls, tags each
// delivered word with its PC, and discards wrong-path words on a redirect.
//   clk, rst                    : clock, synchronous active-high reset
//   imem_req, imem_addr         : fetch request (word aligned address)
//   imem_rdata                  : memory word, valid the cycle after the request
//   redirect_valid, redirect_pc : taken branch/jump/return from ID (pc[1:0] ignored)
//   out_valid, out_ready        : head handshake toward decode
//   out_inst, out_pc            : head instruction and its PC
//   level                       : occupied queue entries (registered)
// Build option: define PREFETCH_BYPASS_EN to present a fresh response directly
// on the outputs when the queue is empty (saves one cycle of latency).
module prefetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                INST_W   = CPU_INST_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INST_W-1:0]           imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [INST_W-1:0]           out_inst,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [$clog2(DEPTH+1)-1:0]  level
);

    localparam int                CNT_W      = $clog2(DEPTH+1);
    localparam int                OCC_W      = CNT_W + 1;
    localparam int                ENT_W      = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic              issue_s;
    logic              resp_s;
    logic              bypass_s;
    logic              push_s;
    logic              pop_s;
    logic [OCC_W-1:0]  occ_s;
    logic [ENT_W-1:0]  wdata_s;
    logic [ENT_W-1:0]  head_s;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;

    prefetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (wdata_s),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Per-cycle decisions: issue, accept the response, and the decode handshake.
    // Counting the in-flight word in the occupancy guarantees a slot for every
    // response, so the queue can never overflow.
    always_comb begin
        occ_s   = {1'b0, count_s} + {{CNT_W{1'b0}}, inflight_q};
        issue_s = !rst && !redirect_valid && !full_s && (occ_s < OCC_W'(DEPTH));
        resp_s  = inflight_q && !kill_q && !redirect_valid;
`ifdef PREFETCH_BYPASS_EN
        bypass_s = resp_s && empty_s;
`else
        bypass_s = 1'b0;
`endif
        out_valid = (!empty_s || bypass_s) && !redirect_valid;
        // A bypassed word never occupies the queue, so a bypass accept is not a pop.
        pop_s     = out_valid && out_ready && !empty_s;
        push_s    = resp_s && !(bypass_s && out_ready);
        wdata_s   = {inflight_pc_q, imem_rdata};
        imem_req  = issue_s;
        imem_addr = fpc_q & ALIGN_MASK;
        level     = count_s;
    end

    // Head fields: queue head, or the fresh response when it is being bypassed.
    always_comb begin
        out_pc   = head_s[ENT_W-1:INST_W];
        out_inst = head_s[INST_W-1:0];
`ifdef PREFETCH_BYPASS_EN
        if (bypass_s) begin
            out_pc   = inflight_pc_q;
            out_inst = imem_rdata;
        end else begin
            out_pc   = head_s[ENT_W-1:INST_W];
            out_inst = head_s[INST_W-1:0];
        end
`endif
    end

    // Fetch-address and in-flight tracking next-state; redirect wins over issue.
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = issue_s;
        inflight_pc_d = inflight_pc_q;
        kill_d        = redirect_valid && inflight_q;
        if (redirect_valid) begin
            fpc_d = redirect_pc & ALIGN_MASK;
        end else if (issue_s) begin
            fpc_d = fpc_q + STEP;
        end else begin
            fpc_d = fpc_q;
        end
        if (issue_s) begin
            inflight_pc_d = fpc_q & ALIGN_MASK;
        end else begin
            inflight_pc_d = inflight_pc_q;
        end
    end

    // Fetch-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc_q         <= RESET_PC & ALIGN_MASK;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            kill_q        <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            kill_q        <= kill_d;
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit. The reference model is the program
// order itself: after reset or a redirect the delivered PCs and the memory
// request addresses must both form the sequential stream target, target+4, ...
module tb_prefetch_unit;
    import cpu_pkg::*;

    localparam int          ADDR_W   = 32;
    localparam int          INST_W   = 32;
    localparam int          DEPTH    = 4;
    localparam int          LVL_W    = $clog2(DEPTH+1);
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
`ifdef PREFETCH_BYPASS_EN
    localparam int          LAT      = 1;
`else
    localparam int          LAT      = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata = 32'h0;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = 32'h0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [LVL_W-1:0]  level;

    prefetch_unit #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .level          (level)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_xfer   = 0;
    int          nreq     = 0;
    int          xfer_mark = 0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_tail = 32'h0;
    logic [31:0] req_exp  = 32'h0;
    logic        mreq     = 1'b0;
    logic [31:0] maddr    = 32'h0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 16) begin
            exp_tail = exp_tail + 32'd4;
            exp_q.push_back(exp_tail);
        end
    endtask

    // Program order restarts at the (aligned) target after reset or redirect.
    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        exp_tail = pc & ~32'h3;
        req_exp  = exp_tail;
        exp_q.push_back(exp_tail);
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        topup();
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // One-cycle reset pulse with decode stalled; returns in cycle 0.
    task automatic pulse_reset();
        rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
        restart(RESET_PC);
        tick();
        rst = 1'b0;
    endtask

    // Synchronous instruction memory: answers the previous cycle's request.
    initial begin
        forever begin
            @(negedge clk);
            mreq  = imem_req;
            maddr = imem_addr;
            @(posedge clk);
            #1;
            imem_rdata = mreq ? word_of(maddr) : $urandom;
        end
    end

    // Monitor: every request and every delivered word against program order.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_req) begin
                check("req_addr", imem_addr, req_exp);
                req_exp = req_exp + 32'd4;
            end
            if (redirect_valid) begin
                check("redirect_quiet", {31'd0, out_valid} | {31'd0, imem_req}, 32'd0);
            end
            if (out_valid && out_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL out_pc: unexpected transfer got %h expected none", out_pc);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_inst", out_inst, word_of(e));
                end
            end
            check("level_range", 32'(level > LVL_W'(DEPTH)), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rpc;
        restart(RESET_PC);
        tick(); tick();
        sample();
        check("rst_req", imem_req, 32'd0);
        check("rst_valid", out_valid, 32'd0);
        check("rst_level", level, 32'd0);

        // Free run: one request and, after the fill latency, one delivery per cycle.
        tick();
        rst = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            sample();
            check("run_req", imem_req, 32'd1);
            check("run_addr", imem_addr, RESET_PC + 32'(4*k));
            check("run_valid", out_valid, {31'd0, (k >= LAT)});
            tick();
        end

        // Decode stalled from cycle 0: exactly DEPTH requests, then hold.
        pulse_reset();
        sample();
        check("rst_next_valid", out_valid, 32'd0);
        check("rst_next_level", level, 32'd0);
        nreq = 0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) sample();
            if (imem_req) nreq++;
            tick();
        end
        check("stall_nreq", nreq, DEPTH);
        sample();
        check("stall_level", level, DEPTH);
        check("stall_req", imem_req, 32'd0);
        check("stall_valid", out_valid, 32'd1);
        tick();
        out_ready = 1'b1;
        sample();
        check("release_req", imem_req, 32'd0);
        tick();
        sample();
        check("resume_req", imem_req, 32'd1);
        check("resume_addr", imem_addr, RESET_PC + 32'd16);
        xfer_mark = n_xfer;
        repeat (8) tick();
        check("drain_progress", 32'(n_xfer - xfer_mark >= 6), 32'd1);

        // Reset pulse while full.
        out_ready = 1'b0;
        repeat (8) tick();
        sample();
        check("full_level", level, DEPTH);
        tick();
        rst = 1'b1; restart(RESET_PC);
        tick();
        rst = 1'b0;
        sample();
        check("rstfull_valid", out_valid, 32'd0);
        check("rstfull_level", level, 32'd0);
        check("rstfull_addr", imem_addr, RESET_PC);
        tick();
        out_ready = 1'b1;
        xfer_mark = n_xfer;
        repeat (8) tick();
        check("rstfull_progress", 32'(n_xfer - xfer_mark >= 5), 32'd1);

        // Redirect with 3 queued words and one in flight.
        pulse_reset();
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        restart(32'h0000_0103);
        sample();
        check("redir_level_before", level, 32'd3);
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        sample();
        check("redir_level_after", level, 32'd0);
        check("redir_req", imem_req, 32'd1);
        check("redir_addr", imem_addr, 32'h0000_0100);
        xfer_mark = n_xfer;
        repeat (10) tick();
        check("redir_progress", 32'(n_xfer - xfer_mark >= 6), 32'd1);

        // Redirect and out_ready together with two queued words.
        pulse_reset();
        repeat (3) tick();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2000_0042;
        restart(32'h2000_0042);
        sample();
        check("same_valid", out_valid, 32'd0);
        check("same_level", level, 32'd2);
        tick();
        redirect_valid = 1'b0;
        sample();
        check("same_level_after", level, 32'd0);
        repeat (8) tick();

        // Random traffic: stalls, redirects and the odd reset.
        for (int k = 0; k < 400; k++) begin
            tick();
            rst = 1'b0; redirect_valid = 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1; out_ready = 1'b0;
                restart(RESET_PC);
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 15) == 0) begin
                    rpc = $urandom;
                    redirect_valid = 1'b1; redirect_pc = rpc;
                    restart(rpc);
                end
            end
        end
        tick();
        rst = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
        xfer_mark = n_xfer;
        repeat (20) tick();
        check("final_progress", 32'(n_xfer - xfer_mark >= 15), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
